// File: rtl/width_upsizer_pkg.sv
// Shared helpers for width_upsizer: counter sizing and the lane index type for
// the default build (WIDTH=8, RATIO=4).
package width_upsizer_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_RATIO = 4;

    // Width of the lane counter; it only has to hold 0..ratio-1.
    function automatic int lane_count_width(input int ratio);
        return (ratio < 2) ? 1 : $clog2(ratio);
    endfunction

    localparam int DEFAULT_LANE_COUNT_WIDTH = $clog2(DEFAULT_RATIO);

    typedef logic [DEFAULT_LANE_COUNT_WIDTH-1:0] lane_idx_t;

endpackage

// File: rtl/width_upsizer.sv
// Packs RATIO successive narrow words into one wide word behind a write_enable/full,
// read_enable/empty interface. Optional partial-word flush: WIDTH_UPSIZER_FLUSH_EN.
module width_upsizer
    import width_upsizer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int RATIO = DEFAULT_RATIO
) (
    input  logic                     clock,
    input  logic                     resetn,
    input  logic                     write_enable,
    input  logic [WIDTH-1:0]         write_data,
    output logic                     full,
    input  logic                     read_enable,
    output logic [WIDTH*RATIO-1:0]   read_data,
    output logic                     empty
`ifdef WIDTH_UPSIZER_FLUSH_EN
    ,
    input  logic                     flush,
    output logic [$clog2(RATIO+1)-1:0] read_lane_count
`endif
);

    localparam int LCW  = lane_count_width(RATIO);
    localparam int OW   = WIDTH * RATIO;
    localparam int SW   = WIDTH * (RATIO - 1);
    localparam logic [LCW-1:0] LAST_LANE = LCW'(RATIO - 1);

    // Handshake: a write is taken on a rising edge when write_enable && !full, a
    // read when read_enable && !empty; requests against a busy side are dropped
    // without side effects, so a producer simply holds its request until taken.

    logic [WIDTH-1:0] staging [RATIO-1];
    logic [LCW-1:0]   lane_count;
    logic [OW-1:0]    out_word;
    logic             output_valid;
    logic [SW-1:0]    staged_word;
    logic             last_lane;
    logic             write_accept;
    logic             read_accept;

    assign last_lane   = (lane_count == LAST_LANE);
    assign read_accept = read_enable && output_valid;
    assign empty       = !output_valid;
    assign read_data   = out_word;

    always_comb begin
        staged_word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            staged_word[i*WIDTH +: WIDTH] = staging[i];
        end
    end

`ifdef WIDTH_UPSIZER_FLUSH_EN
    localparam int RLCW = $clog2(RATIO + 1);

    logic            flush_fire;
    logic [OW-1:0]   flush_word;
    logic [RLCW-1:0] lane_count_out;

    // Unfilled lanes read as zero so a consumer can ignore read_lane_count safely.
    always_comb begin
        flush_word = '0;
        for (int i = 0; i < RATIO - 1; i++) begin
            if (i < int'(lane_count)) begin
                flush_word[i*WIDTH +: WIDTH] = staging[i];
            end
        end
    end

    // A flush only lands when the output slot is free or being vacated this cycle.
    assign flush_fire      = flush && (lane_count != '0) && (!output_valid || read_accept);
    assign full            = (output_valid && last_lane) || flush;
    assign write_accept    = write_enable && !full;
    assign read_lane_count = lane_count_out;
`else
    assign full         = output_valid && last_lane;
    assign write_accept = write_enable && !full;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lane_count   <= '0;
            out_word     <= '0;
            output_valid <= 1'b0;
            for (int i = 0; i < RATIO - 1; i++) begin
                staging[i] <= '0;
            end
`ifdef WIDTH_UPSIZER_FLUSH_EN
            lane_count_out <= '0;
`endif
        end else begin
            if (read_accept) begin
                output_valid <= 1'b0;
            end
`ifdef WIDTH_UPSIZER_FLUSH_EN
            if (flush_fire) begin
                out_word       <= flush_word;
                lane_count_out <= RLCW'(lane_count);
                output_valid   <= 1'b1;
                lane_count     <= '0;
            end else
`endif
            if (write_accept) begin
                if (last_lane) begin
                    // full guarantees the slot is empty or being read this cycle.
                    out_word     <= {write_data, staged_word};
                    output_valid <= 1'b1;
                    lane_count   <= '0;
`ifdef WIDTH_UPSIZER_FLUSH_EN
                    lane_count_out <= RLCW'(RATIO);
`endif
                end else begin
                    staging[lane_count] <= write_data;
                    lane_count          <= lane_count + LCW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_width_upsizer.sv
// Self-checking bench for width_upsizer: lane-queue reference model, wide-word
// scoreboard, directed cases and a randomized chain behind a narrow bypass buffer.
module tb_width_upsizer;

    localparam int W     = 8;
    localparam int RATIO = 4;
    localparam int OW    = W * RATIO;
    localparam int BUF_DEPTH = 2;

    logic          clock;
    logic          resetn;
    logic          write_enable;
    logic [W-1:0]  write_data;
    logic          full;
    logic          read_enable;
    logic [OW-1:0] read_data;
    logic          empty;
    logic          flush_i;
`ifdef WIDTH_UPSIZER_FLUSH_EN
    logic [$clog2(RATIO+1)-1:0] read_lane_count;
`endif

    width_upsizer #(.WIDTH(W), .RATIO(RATIO)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .write_enable (write_enable),
        .write_data   (write_data),
        .full         (full),
        .read_enable  (read_enable),
        .read_data    (read_data),
        .empty        (empty)
`ifdef WIDTH_UPSIZER_FLUSH_EN
        ,
        .flush           (flush_i),
        .read_lane_count (read_lane_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests_run = 0;
    int tests_failed = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Pending narrow lanes as a queue; a wide word exists or it does not.
    logic [W-1:0]  m_pend [$];
    bit            m_valid;
    logic [OW-1:0] m_data;
    int            m_rlc;

    function automatic logic [OW-1:0] pack_lanes(input logic [W-1:0] l [$]);
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < l.size(); i++) r[i*W +: W] = l[i];
        return r;
    endfunction

    function automatic bit model_full();
        return (m_valid && m_pend.size() == RATIO - 1) || (flush_i === 1'b1);
    endfunction

    task automatic model_reset();
        m_pend.delete();
        m_valid = 1'b0;
        m_data  = '0;
        m_rlc   = 0;
    endtask

    always @(posedge clock) begin
        if (resetn) begin
            bit wa, ra, ff;
            wa = write_enable && !model_full();
            ra = read_enable && m_valid;
            ff = (flush_i === 1'b1) && m_pend.size() > 0 && (!m_valid || ra);
            if (ra) m_valid = 1'b0;
            if (ff) begin
                m_data  = pack_lanes(m_pend);
                m_rlc   = m_pend.size();
                m_pend.delete();
                m_valid = 1'b1;
            end else if (wa) begin
                m_pend.push_back(write_data);
                if (m_pend.size() == RATIO) begin
                    m_data  = pack_lanes(m_pend);
                    m_rlc   = RATIO;
                    m_pend.delete();
                    m_valid = 1'b1;
                end
            end
        end
    end

    // Compare process: outputs against the model, just after every rising edge.
    always @(posedge clock) begin
        #1;
        if (chk_on) begin
            check("model_empty", 64'(empty), 64'(!m_valid));
            check("model_full", 64'(full), 64'(model_full()));
            check("model_read_data", 64'(read_data), 64'(m_data));
`ifdef WIDTH_UPSIZER_FLUSH_EN
            check("model_lane_count", 64'(read_lane_count), 64'(m_rlc));
`endif
        end
    end

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q [$];
    logic [W-1:0]  sb_lanes [$];

    task automatic sb_push_lane(input logic [W-1:0] d);
        sb_lanes.push_back(d);
        if (sb_lanes.size() == RATIO) begin
            exp_q.push_back(pack_lanes(sb_lanes));
            sb_lanes.delete();
        end
    endtask

    task automatic sb_read_check();
        if (exp_q.size() == 0) begin
            check("sb_underflow", 64'(exp_q.size()), 64'd1);
        end else begin
            check("sb_word", 64'(read_data), 64'(exp_q.pop_front()));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic we, input logic [W-1:0] wd, input logic re, input logic fl);
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        flush_i      = fl;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        flush_i      = 1'b0;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [W-1:0] buf_q [$];
    int words_read;
    int stall;
    int cycles;
    int gen_count;
    bit full_seen;

    initial begin
        write_data = '0;
        @(negedge clock);
        do_reset();
        chk_on = 1'b1;

        // Reset state
        check("reset_empty", 64'(empty), 64'd1);
        check("reset_full", 64'(full), 64'd0);
        check("reset_read_data", 64'(read_data), 64'd0);

        // Basic packing and one-cycle latency
        drive(1, 8'h11, 0, 0);
        drive(1, 8'h22, 0, 0);
        drive(1, 8'h33, 0, 0);
        check("basic_empty_before", 64'(empty), 64'd1);
        drive(1, 8'h44, 0, 0);
        check("basic_empty_after", 64'(empty), 64'd0);
        check("basic_word", 64'(read_data), 64'h44332211);
        drive(0, 8'h00, 1, 0);
        check("basic_empty_read", 64'(empty), 64'd1);
        check("basic_hold", 64'(read_data), 64'h44332211);

        // Back-pressure: 8 writes, no reads
        for (int i = 0; i < 7; i++) drive(1, W'(i), 0, 0);
        check("bp_full", 64'(full), 64'd1);
        drive(1, 8'h07, 0, 0);
        check("bp_full_held", 64'(full), 64'd1);
        check("bp_word", 64'(read_data), 64'h03020100);
        drive(0, 8'h00, 1, 0);
        check("bp_full_cleared", 64'(full), 64'd0);
        drive(1, 8'h07, 0, 0);
        check("bp_second_word", 64'(read_data), 64'h07060504);
        drive(0, 8'h00, 1, 0);

        // Reset discards a partial word
        drive(1, 8'hAA, 0, 0);
        drive(1, 8'hBB, 0, 0);
        do_reset();
        check("rst_mid_empty", 64'(empty), 64'd1);
        for (int i = 1; i <= 4; i++) drive(1, W'(i), 0, 0);
        check("rst_mid_word", 64'(read_data), 64'h04030201);
        drive(0, 8'h00, 1, 0);

`ifdef WIDTH_UPSIZER_FLUSH_EN
        // Flush of a partial word
        drive(0, 8'h00, 0, 1);
        check("flush_nothing_staged", 64'(empty), 64'd1);
        drive(1, 8'hAA, 0, 0);
        drive(1, 8'hBB, 0, 0);
        drive(1, 8'hCC, 0, 1);
        check("flush_word", 64'(read_data), 64'h0000BBAA);
        check("flush_lane_count", 64'(read_lane_count), 64'd2);
        drive(0, 8'h00, 1, 0);
`endif

        // Continuous flow: a write every cycle, read whenever a word is visible
        do_reset();
        exp_q.delete();
        sb_lanes.delete();
        full_seen = 1'b0;
        for (int i = 0; i < 100 * RATIO; i++) begin
            logic [W-1:0] d;
            logic re;
            d  = W'($urandom_range(0, 255));
            re = !empty;
            if (full) full_seen = 1'b1;
            if (re) sb_read_check();
            sb_push_lane(d);
            drive(1, d, re, 0);
        end
        if (!empty) begin
            sb_read_check();
            drive(0, 8'h00, 1, 0);
        end
        check("flow_full_never", 64'(full_seen), 64'd0);
        check("flow_all_read", 64'(exp_q.size()), 64'd0);

        // Chained behind a narrow bypass buffer, random enables both sides
        do_reset();
        exp_q.delete();
        sb_lanes.delete();
        buf_q.delete();
        words_read = 0;
        stall = 0;
        cycles = 0;
        gen_count = 0;
        while (words_read < 100 && cycles < 20000) begin
            logic we, re;
            logic [W-1:0] wd;
            if (gen_count < 100 * RATIO && buf_q.size() < BUF_DEPTH && $urandom_range(0, 1) == 1) begin
                logic [W-1:0] g;
                g = W'($urandom_range(0, 255));
                buf_q.push_back(g);
                sb_push_lane(g);
                gen_count++;
            end
            we = (buf_q.size() > 0) && !full && ($urandom_range(0, 1) == 1);
            wd = (buf_q.size() > 0) ? buf_q[0] : W'(0);
            if (we) void'(buf_q.pop_front());
            re = !empty && ($urandom_range(0, 1) == 1);
            if (re) begin
                sb_read_check();
                words_read++;
                stall = 0;
            end else begin
                stall++;
            end
            drive(we, wd, re, 0);
            cycles++;
            if (stall > 1000) begin
                tests_run++;
                tests_failed++;
                $display("FAIL chain_timeout: got %0d words expected 100", words_read);
                break;
            end
        end
        check("chain_words", 64'(words_read), 64'd100);
        check("chain_no_leftover", 64'(exp_q.size()), 64'd0);

        chk_on = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
